// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster constants shared by the timing generator,
// the pixel generator and the paddle/ball datapath.
package vga_pkg;

    localparam int CNT_W    = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // 0 = active-low syncs, the 640x480 standard
    localparam logic SYNC_POL = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    // registered video bundle leaving the chip
    typedef struct packed {
        logic r;
        logic g;
        logic b;
        logic hsync;
        logic vsync;
        logic active;
    } vid_t;

    // inclusive window test on a raster counter
    function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// vga_mod_counter: enabled modulo-N counter whose wrap flag is a register
// that is high exactly while count sits on its last value (N-1).
module vga_mod_counter
    import vga_pkg::*;
#(
    parameter int N = 800
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    // width and range guard: the count must fit CNT_W bits
    if (N < 2 || N > (1 << CNT_W)) begin : g_bad_n
        $error("vga_mod_counter: N out of range");
    end

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(N - 2);

    // count up on en, wrap to 0 after N-1; wrap flag precomputed one step early
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                count <= '0;
                wrap  <= 1'b0;
            end else begin
                count <= count + CNT_W'(1);
                wrap  <= (count == PRE_LAST);
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/active decode and the output
// register that keeps colour and sync aligned, plus frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] column,
    output logic [CNT_W-1:0] row,
    input  logic             r_in,
    input  logic             g_in,
    input  logic             b_in,
    output logic             r,
    output logic             g,
    output logic             b,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             frame_tick,
    output logic             frame_start
);

    localparam int T_H = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int T_V = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_L = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic h_wrap;
    logic v_wrap;
    logic v_en;
    logic act_c;
    logic hs_c;
    logic vs_c;
    vid_t vid_q;

    vga_mod_counter #(.N(T_H)) u_hcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .count (column),
        .wrap  (h_wrap)
    );

    // row advances on the same tick that column wraps
    assign v_en = pix_en & h_wrap;

    vga_mod_counter #(.N(T_V)) u_vcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (v_en),
        .count (row),
        .wrap  (v_wrap)
    );

    // decode active area and sync windows from the live counters
    always_comb begin
        act_c = (column < H_ACT) && (row < V_ACT);
        hs_c  = in_range(column, HS_LO, HS_HI);
        vs_c  = in_range(row, VS_LO, VS_HI);
    end

    // one register stage for colour, syncs and active so they leave together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_q.r      <= 1'b0;
            vid_q.g      <= 1'b0;
            vid_q.b      <= 1'b0;
            vid_q.hsync  <= ~SYNC_POL;
            vid_q.vsync  <= ~SYNC_POL;
            vid_q.active <= 1'b0;
        end else if (pix_en) begin
            vid_q.r      <= r_in & act_c;
            vid_q.g      <= g_in & act_c;
            vid_q.b      <= b_in & act_c;
            vid_q.hsync  <= hs_c ? SYNC_POL : ~SYNC_POL;
            vid_q.vsync  <= vs_c ? SYNC_POL : ~SYNC_POL;
            vid_q.active <= act_c;
        end
    end

    // single-clk strobes on entry to vblank and on the wrap to (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_tick  <= v_en & (row == V_ACT_L);
            frame_start <= v_en & v_wrap;
        end
    end

    assign r      = vid_q.r;
    assign g      = vid_q.g;
    assign b      = vid_q.b;
    assign hsync  = vid_q.hsync;
    assign vsync  = vid_q.vsync;
    assign active = vid_q.active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives a full-size and a shrunken-raster instance in
// lockstep against a position-from-tick-count model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    } geom_t;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic r, g, b, hs, vs, act, ft, fs;
    } obs_t;

    typedef struct {
        bit         en;
        bit         rgb;
        logic [9:0] col;
        logic [9:0] row;
        logic       r;
        logic       act;
        logic       ft;
    } vec_t;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int S_VA = 8,  S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = 25, S_VT = 15, S_FR = S_HT * S_VT;
    localparam int F_HT = 800;

    logic clk = 1'b0;
    logic rst_n, pix_en, r_in, g_in, b_in;

    logic [9:0] s_col, s_row, f_col, f_row;
    logic s_r, s_g, s_b, s_hs, s_vs, s_act, s_ft, s_fs;
    logic f_r, f_g, f_b, f_hs, f_vs, f_act, f_ft, f_fs;

    int n_pass, n_total;
    int ns, nf;
    obs_t last_s, last_f;
    obs_t q_s[$];
    obs_t q_f[$];
    geom_t gs, gf;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .column(s_col), .row(s_row),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .r(s_r), .g(s_g), .b(s_b),
        .hsync(s_hs), .vsync(s_vs), .active(s_act),
        .frame_tick(s_ft), .frame_start(s_fs)
    );

    vga_timing_gen u_full (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .column(f_col), .row(f_row),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .r(f_r), .g(f_g), .b(f_b),
        .hsync(f_hs), .vsync(f_vs), .active(f_act),
        .frame_tick(f_ft), .frame_start(f_fs)
    );

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // n = enabled ticks since reset before this edge
    function automatic obs_t predict(geom_t gm, int n, obs_t prev,
                                     bit en, bit rr, bit gg, bit bb);
        obs_t o;
        int ht, vt, c, rw;
        bit a;
        ht = gm.ha + gm.hfp + gm.hs + gm.hbp;
        vt = gm.va + gm.vfp + gm.vs + gm.vbp;
        o = prev;
        o.ft = 1'b0;
        o.fs = 1'b0;
        if (en) begin
            c  = n % ht;
            rw = (n / ht) % vt;
            a  = (c < gm.ha) && (rw < gm.va);
            o.col = 10'((n + 1) % ht);
            o.row = 10'(((n + 1) / ht) % vt);
            o.r   = rr & a;
            o.g   = gg & a;
            o.b   = bb & a;
            o.act = a;
            o.hs  = !((c >= gm.ha + gm.hfp) && (c < gm.ha + gm.hfp + gm.hs));
            o.vs  = !((rw >= gm.va + gm.vfp) && (rw < gm.va + gm.vfp + gm.vs));
            o.ft  = (c == ht - 1) && (rw == gm.va - 1);
            o.fs  = (c == ht - 1) && (rw == vt - 1);
        end
        return o;
    endfunction

    function automatic obs_t sample_s();
        obs_t o;
        o = {s_col, s_row, s_r, s_g, s_b, s_hs, s_vs, s_act, s_ft, s_fs};
        return o;
    endfunction

    function automatic obs_t sample_f();
        obs_t o;
        o = {f_col, f_row, f_r, f_g, f_b, f_hs, f_vs, f_act, f_ft, f_fs};
        return o;
    endfunction

    function automatic void chk(string nm, longint got, longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endfunction

    task automatic step(bit en, bit rr, bit gg, bit bb);
        obs_t es, ef;
        @(negedge clk);
        pix_en = en;
        r_in   = rr;
        g_in   = gg;
        b_in   = bb;
        es = predict(gs, ns, last_s, en, rr, gg, bb);
        ef = predict(gf, nf, last_f, en, rr, gg, bb);
        q_s.push_back(es);
        q_f.push_back(ef);
        last_s = es;
        last_f = ef;
        if (en) begin
            ns++;
            nf++;
        end
        @(posedge clk);
        #1;
        chk("sb_small", sample_s(), q_s.pop_front());
        chk("sb_full", sample_f(), q_f.pop_front());
    endtask

    task automatic run_rand(int k);
        for (int i = 0; i < k; i++)
            step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)));
    endtask

    task automatic small_to(int c, int rw);
        int tgt;
        tgt = rw * S_HT + c;
        run_rand((tgt - ns % S_FR + S_FR) % S_FR);
    endtask

    vec_t tbl[5];

    initial begin
        int k, lo, slo, rc, vlo, fsn, ftn, last_fs, gap_bad, ramis, dbl;
        bit prev_ft;

        gs = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};
        gf = '{640, 16, 96, 48, 480, 10, 2, 33};

        tbl[0] = '{1'b1, 1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 10'd2, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 10'd2, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 10'd3, 10'd0, 1'b1, 1'b1, 1'b0};

        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        pix_en = 1'b0;
        r_in = 1'b0;
        g_in = 1'b0;
        b_in = 1'b0;
        ns = 0;
        nf = 0;
        last_s = reset_obs();
        last_f = reset_obs();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_small", sample_s(), reset_obs());
        chk("reset_full", sample_f(), reset_obs());
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(tbl[i].en, tbl[i].rgb, tbl[i].rgb, tbl[i].rgb);
            chk("tbl_s_col", s_col, tbl[i].col);
            chk("tbl_s_row", s_row, tbl[i].row);
            chk("tbl_s_r", s_r, tbl[i].r);
            chk("tbl_s_act", s_act, tbl[i].act);
            chk("tbl_s_ft", s_ft, tbl[i].ft);
            chk("tbl_f_col", f_col, tbl[i].col);
            chk("tbl_f_r", f_r, tbl[i].r);
        end

        k = (655 - nf % F_HT + F_HT) % F_HT;
        run_rand(k);
        chk("f_col_655", f_col, 655);
        run_rand(1);
        chk("f_col_656", f_col, 656);
        chk("hs_at_656", f_hs, 1);
        run_rand(1);
        chk("hs_at_657", f_hs, 0);
        run_rand(752 - 657);
        chk("f_col_752", f_col, 752);
        chk("hs_at_752", f_hs, 0);
        run_rand(1);
        chk("hs_at_753", f_hs, 1);

        lo = 0;
        slo = 0;
        for (int i = 0; i < F_HT; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (!f_hs) lo++;
            if (!s_hs) slo++;
        end
        chk("f_hs_low_per_line", lo, 96);
        chk("s_hs_low_32_lines", slo, 32 * S_HS);

        small_to(S_HT - 1, S_VA - 1);
        chk("s_pre_tick_col", s_col, S_HT - 1);
        chk("s_pre_tick_row", s_row, S_VA - 1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("ft_col", s_col, 0);
        chk("ft_row", s_row, S_VA);
        chk("ft_high", s_ft, 1);
        chk("ft_fs_low", s_fs, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("ft_single", s_ft, 0);
        chk("ft_hold_col", s_col, 0);

        small_to(S_HT - 1, S_VT - 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fs_col", s_col, 0);
        chk("fs_row", s_row, 0);
        chk("fs_high", s_fs, 1);
        chk("fs_ft_low", s_ft, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fs_single", s_fs, 0);

        rc = 0; vlo = 0; fsn = 0; ftn = 0;
        last_fs = -1; gap_bad = 0; ramis = 0; dbl = 0;
        prev_ft = 1'b0;
        for (int c = 0; c < 2 * S_FR; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (c < S_FR) begin
                if (s_r) rc++;
                if (!s_vs) vlo++;
            end
            if (s_r != s_act) ramis++;
            if (s_fs) begin
                if (last_fs >= 0 && c - last_fs != S_FR) gap_bad++;
                last_fs = c;
                fsn++;
            end
            if (s_ft) begin
                ftn++;
                if (prev_ft) dbl++;
            end
            prev_ft = s_ft;
        end
        chk("r_count_frame", rc, S_HA * S_VA);
        chk("vs_low_frame", vlo, S_VS * S_HT);
        chk("r_eq_active", ramis, 0);
        chk("fs_count", fsn, 2);
        chk("fs_gap_bad", gap_bad, 0);
        chk("ft_count", ftn, 2);
        chk("ft_double", dbl, 0);

        small_to(10, 5);
        @(negedge clk);
        pix_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_small", sample_s(), reset_obs());
        chk("rst_async_full", sample_f(), reset_obs());
        ns = 0;
        nf = 0;
        last_s = reset_obs();
        last_f = reset_obs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_small", sample_s(), reset_obs());
        chk("rst_hold_full", sample_f(), reset_obs());
        @(negedge clk);
        rst_n = 1'b1;
        pix_en = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rel_col", s_col, 1);
        chk("rel_row", s_row, 0);
        chk("rel_ft", s_ft, 0);
        chk("rel_fs", s_fs, 0);
        chk("rel_f_col", f_col, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
